cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss/refill sequencer for the 4-way set-associative cache.
//  - On a hit, forwards the hit way to LRU_replace as a one-cycle update.
//  - On a miss, latches the LRU victim way for the set, fetches the line from memory as a burst, and writes each beat into the victim way.
//  - After the last beat, sets the victim's tag/valid and marks it MRU.
//  - Sits between tag compare, LRU_replace, the data/tag arrays and the memory bus.
// PARAMETERS
//  WAY_NUM      4   ways per set; hit_en and the *_we outputs are one-hot of this width
//  INDEX_WIDTH  4   set index bits (16 sets)
//  OFFSET_WIDTH 2   word-in-line bits (2**OFFSET_WIDTH beats per line)
//  ADDR_WIDTH   32  byte address width
//  DATA_WIDTH   32  word / beat width; 4 bytes, so addr[1:0] is the byte offset
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  async active-low reset
//  cpu_req      in   1                  access valid this cycle
//  cpu_addr     in   ADDR_WIDTH         access address; index = addr[OFFSET_WIDTH+2 +: INDEX_WIDTH]
//  hit_en       in   WAY_NUM            tag-compare result, one-hot; 0 = miss
//  replace_way  in   $clog2(WAY_NUM)+1  LRU victim for the set of cpu_addr; low $clog2(WAY_NUM) bits used
//  cpu_stall    out  1                  hold the CPU access (combinational)
//  lru_hit_en   out  WAY_NUM            one-cycle LRU update pulse
//  lru_index    out  INDEX_WIDTH        set for lru_hit_en
//  mem_req      out  1                  line-read request; held until mem_ack
//  mem_addr     out  ADDR_WIDTH         line-aligned address; low OFFSET_WIDTH+2 bits are 0
//  mem_ack      in   1                  request accepted
//  mem_rvalid   in   1                  read beat valid
//  mem_rdata    in   DATA_WIDTH         read beat data
//  refill_we    out  WAY_NUM            data-array write, one-hot victim way
//  refill_index out  INDEX_WIDTH        set being refilled
//  refill_word  out  OFFSET_WIDTH       word within the line
//  refill_wdata out  DATA_WIDTH         = mem_rdata, registered
//  tag_we       out  WAY_NUM            tag/valid write, one-hot, pulsed with the last data write
// BEHAVIOUR
//  - Reset: all registered outputs are 0, state IDLE, beat count 0.
//  - FSM states: IDLE, REQ, FILL, DONE.
//  - IDLE, cpu_req & |hit_en (hit):
//    - next cycle lru_hit_en=hit_en and lru_index=index; cpu_stall=0.
//  - IDLE, cpu_req & hit_en==0 (miss):
//    - cpu_stall=1 in the same cycle.
//    - Latch victim one-hot, index and line address; -> REQ.
//  - REQ: mem_req=1 with mem_addr stable. On mem_ack -> FILL with beat count 0. mem_rvalid is ignored in REQ.
//  - FILL: each mem_rvalid registers one write:
//    - refill_we=victim, refill_word=count, refill_wdata=mem_rdata, one cycle later.
//    - count then increments; a cycle without rvalid writes nothing.
//    - On the last beat (count==2**OFFSET_WIDTH-1): tag_we=victim with that write, count wraps to 0, -> DONE.
//  - DONE: lru_hit_en=victim and lru_index=latched index for one cycle; -> IDLE.
//  - cpu_stall=1 in REQ, FILL and DONE, and in IDLE on a miss. The CPU retries in IDLE and hits.
//  - Victim, index and address are latched only at miss detection. replace_way/cpu_addr changes mid-refill are ignored.
//  - If cpu_req drops mid-refill, the refill still completes.
//  - Multi-hot hit_en is illegal; it is forwarded unchanged and not checked.
//  - replace_way >= WAY_NUM: use its low bits only (no error).
//  - Reset mid-refill: immediate return to IDLE with outputs 0. No tag_we is issued, so the partial line stays invalid.
//  - Latency: hit -> LRU update is 1 cycle. Miss -> stall release is ack + beats + 2 cycles.
// TESTING
//  1. Hit: cpu_req, addr 0x0000_0034 (index 3), hit_en=4'b0100
//     -> next cycle lru_hit_en=4'b0100, lru_index=3; mem_req never set; cpu_stall=0.
//  2. Miss: addr 0x0000_1234, replace_way=2, ack at once, 4 back-to-back beats D0..D3
//     -> mem_addr=0x0000_1230; refill_we=4'b0100 with words 0..3 = D0..D3, index 3.
//     -> tag_we=4'b0100 with word 3; then lru_hit_en=4'b0100 for one cycle; stall drops the next cycle.
//  3. mem_ack delayed 5 cycles -> mem_req high and mem_addr constant for all 5 cycles; early rvalid ignored.
//  4. Beats with gaps (rvalid 1,0,1,0,0,1,1) -> exactly 4 writes, words 0..3 in order; no write on gap cycles.
//  5. rst_n low after 2 beats -> all outputs 0, IDLE, no tag_we. A later miss to the same set restarts at word 0.
//  6. replace_way changes 2->0 during FILL, cpu_req dropped -> refill_we stays 4'b0100 and the refill completes.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer for a set-associative cache: forwards hits to LRU,
// fetches a missing line as a burst into the LRU victim way, then tags it and marks it MRU.
module cache_refill_ctrl #(
  parameter int WAY_NUM      = 4,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [WAY_NUM-1:0]          hit_en,
  input  logic [$clog2(WAY_NUM):0]    replace_way,
  output logic                        cpu_stall,
  output logic [WAY_NUM-1:0]          lru_hit_en,
  output logic [INDEX_WIDTH-1:0]      lru_index,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ack,
  input  logic                        mem_rvalid,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic [WAY_NUM-1:0]          refill_we,
  output logic [INDEX_WIDTH-1:0]      refill_index,
  output logic [OFFSET_WIDTH-1:0]     refill_word,
  output logic [DATA_WIDTH-1:0]       refill_wdata,
  output logic [WAY_NUM-1:0]          tag_we
);

  localparam int WAY_W    = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int LINE_LSB = OFFSET_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WAY_NUM-1:0]      victim_q;
  logic [WAY_NUM-1:0]      victim_sel;
  logic [OFFSET_WIDTH-1:0] count_q;
  logic [INDEX_WIDTH-1:0]  cpu_index;
  logic                    is_hit, is_miss, last_beat;
  logic                    unused_bits;

  assign cpu_index = cpu_addr[LINE_LSB +: INDEX_WIDTH];
  assign is_hit    = cpu_req & (|hit_en);
  assign is_miss   = cpu_req & ~(|hit_en);
  assign last_beat = (count_q == '1);

  // Out-of-range victims alias onto a real way via their low bits.
  assign unused_bits = ^{replace_way[$clog2(WAY_NUM)], cpu_addr[LINE_LSB-1:0]};

  always_comb begin
    victim_sel = '0;
    victim_sel[replace_way[WAY_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_miss) begin
          cpu_stall = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (mem_rvalid && last_beat) state_d = DONE;
      end
      DONE: begin
        cpu_stall = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_q     <= '0;
      count_q      <= '0;
      lru_hit_en   <= '0;
      lru_index    <= '0;
      mem_addr     <= '0;
      refill_we    <= '0;
      refill_index <= '0;
      refill_word  <= '0;
      refill_wdata <= '0;
      tag_we       <= '0;
    end else begin
      lru_hit_en <= '0;
      refill_we  <= '0;
      tag_we     <= '0;
      case (state_q)
        IDLE: begin
          if (is_hit) begin
            lru_hit_en <= hit_en;
            lru_index  <= cpu_index;
          end else if (is_miss) begin
            victim_q     <= victim_sel;
            refill_index <= cpu_index;
            mem_addr     <= {cpu_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
          end
        end
        REQ: begin
          if (mem_ack) count_q <= '0;
        end
        FILL: begin
          if (mem_rvalid) begin
            refill_we    <= victim_q;
            refill_word  <= count_q;
            refill_wdata <= mem_rdata;
            count_q      <= count_q + 1'b1;
            if (last_beat) tag_we <= victim_q;
          end
        end
        DONE: begin
          lru_hit_en <= victim_q;
          lru_index  <= refill_index;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed and randomized bench for cache_refill_ctrl; expectations come from a
// transaction-level model of hits, line refills and reset aborts.
module tb_cache_refill_ctrl;

  localparam int WAY_NUM      = 4;
  localparam int INDEX_WIDTH  = 4;
  localparam int OFFSET_WIDTH = 2;
  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int BEATS        = 1 << OFFSET_WIDTH;

  logic                    clk;
  logic                    rst_n;
  logic                    cpu_req;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [WAY_NUM-1:0]      hit_en;
  logic [2:0]              replace_way;
  logic                    cpu_stall;
  logic [WAY_NUM-1:0]      lru_hit_en;
  logic [INDEX_WIDTH-1:0]  lru_index;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ack;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [WAY_NUM-1:0]      refill_we;
  logic [INDEX_WIDTH-1:0]  refill_index;
  logic [OFFSET_WIDTH-1:0] refill_word;
  logic [DATA_WIDTH-1:0]   refill_wdata;
  logic [WAY_NUM-1:0]      tag_we;

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl #(
    .WAY_NUM(WAY_NUM), .INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .hit_en(hit_en), .replace_way(replace_way), .cpu_stall(cpu_stall),
    .lru_hit_en(lru_hit_en), .lru_index(lru_index), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .refill_we(refill_we), .refill_index(refill_index),
    .refill_word(refill_word), .refill_wdata(refill_wdata), .tag_we(tag_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Inputs change just after the rising edge; outputs are observed on the falling edge.
  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pt();
    @(negedge clk);
  endtask

  function automatic logic [31:0] idx_of(input logic [31:0] addr);
    return (addr / 32'(4 * BEATS)) % 32'(1 << INDEX_WIDTH);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] addr);
    return addr - (addr % 32'(4 * BEATS));
  endfunction

  function automatic logic [31:0] onehot(input int way);
    return 32'(1) << (way % WAY_NUM);
  endfunction

  task automatic do_hit(input logic [31:0] addr, input logic [3:0] h);
    drive_pt();
    cpu_req = 1'b1; cpu_addr = addr; hit_en = h;
    replace_way = 3'($urandom_range(0, 7));
    sample_pt();
    chk("hit_stall", 32'(cpu_stall), 32'd0);
    chk("hit_mem_req", 32'(mem_req), 32'd0);
    drive_pt();
    cpu_req = 1'b0; hit_en = '0; cpu_addr = $urandom;
    sample_pt();
    chk("hit_lru_en", 32'(lru_hit_en), 32'(h));
    chk("hit_lru_index", 32'(lru_index), idx_of(addr));
    chk("hit_mem_req_after", 32'(mem_req), 32'd0);
  endtask

  // One miss: ack after ack_dly idle REQ cycles; rvalid follows pat for pat_len
  // cycles then is random. abort_after >= 0 pulls reset once that many beats were sent.
  task automatic do_miss(input logic [31:0] addr, input int way, input int ack_dly,
                         input logic [15:0] pat, input int pat_len, input int abort_after);
    logic [31:0] vic, line, idx, exp_we, exp_tag, exp_data;
    int          exp_word, beat, cyc;
    logic        v;
    vic = onehot(way); line = line_of(addr); idx = idx_of(addr);
    beat = 0; cyc = 0; exp_we = 0; exp_tag = 0; exp_data = 0; exp_word = 0;

    drive_pt();
    cpu_req = 1'b1; cpu_addr = addr; hit_en = '0; replace_way = 3'(way);
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    sample_pt();
    chk("miss_stall", 32'(cpu_stall), 32'd1);
    chk("miss_mem_req", 32'(mem_req), 32'd0);
    chk("miss_lru_quiet", 32'(lru_hit_en), 32'd0);

    for (int i = 0; i <= ack_dly; i++) begin
      drive_pt();
      cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
      replace_way = 3'($urandom_range(0, 7));
      mem_ack = (i == ack_dly); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      sample_pt();
      chk("req_mem_req", 32'(mem_req), 32'd1);
      chk("req_mem_addr", mem_addr, line);
      chk("req_stall", 32'(cpu_stall), 32'd1);
      chk("req_no_write", 32'(refill_we), 32'd0);
    end

    while (beat < BEATS) begin
      drive_pt();
      mem_ack = 1'b0; cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
      replace_way = 3'($urandom_range(0, 7));
      if (abort_after >= 0 && beat == abort_after) begin
        rst_n = 1'b0; cpu_req = 1'b0; mem_rvalid = 1'b0;
        sample_pt();
        chk("rst_refill_we", 32'(refill_we), 32'd0);
        chk("rst_tag_we", 32'(tag_we), 32'd0);
        chk("rst_lru_en", 32'(lru_hit_en), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_refill_index", 32'(refill_index), 32'd0);
        chk("rst_refill_wdata", refill_wdata, 32'd0);
        drive_pt();
        rst_n = 1'b1;
        return;
      end
      if (cyc < pat_len)  v = pat[cyc];
      else if (cyc > 64)  v = 1'b1;
      else                v = ($urandom_range(0, 3) != 0);
      mem_rvalid = v; mem_rdata = $urandom;
      sample_pt();
      chk("fill_refill_we", 32'(refill_we), exp_we);
      chk("fill_tag_we", 32'(tag_we), exp_tag);
      chk("fill_stall", 32'(cpu_stall), 32'd1);
      chk("fill_mem_req", 32'(mem_req), 32'd0);
      if (exp_we != 0) begin
        chk("fill_word", 32'(refill_word), 32'(exp_word));
        chk("fill_wdata", refill_wdata, exp_data);
        chk("fill_index", 32'(refill_index), idx);
      end
      if (v) begin
        exp_we = vic; exp_word = beat; exp_data = mem_rdata;
        exp_tag = (beat == BEATS - 1) ? vic : 32'd0;
        beat++;
      end else begin
        exp_we = 0; exp_tag = 0;
      end
      cyc++;
    end

    drive_pt();
    mem_rvalid = 1'($urandom_range(0, 1)); cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
    sample_pt();
    chk("last_refill_we", 32'(refill_we), vic);
    chk("last_word", 32'(refill_word), 32'(BEATS - 1));
    chk("last_wdata", refill_wdata, exp_data);
    chk("last_tag_we", 32'(tag_we), vic);
    chk("done_stall", 32'(cpu_stall), 32'd1);
    chk("done_lru_quiet", 32'(lru_hit_en), 32'd0);

    drive_pt();
    cpu_req = 1'b0; mem_rvalid = 1'b0;
    sample_pt();
    chk("release_stall", 32'(cpu_stall), 32'd0);
    chk("mru_lru_en", 32'(lru_hit_en), vic);
    chk("mru_lru_index", 32'(lru_index), idx);
    chk("release_refill_we", 32'(refill_we), 32'd0);
    chk("release_tag_we", 32'(tag_we), 32'd0);
    chk("release_mem_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; hit_en = '0; replace_way = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    sample_pt();
    sample_pt();
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_lru_en", 32'(lru_hit_en), 32'd0);
    chk("reset_refill_we", 32'(refill_we), 32'd0);
    chk("reset_tag_we", 32'(tag_we), 32'd0);
    chk("reset_refill_wdata", refill_wdata, 32'd0);
    drive_pt();
    rst_n = 1'b1;

    do_hit(32'h0000_0034, 4'b0100);
    do_miss(32'h0000_1234, 2, 0, 16'hFFFF, 16, -1);
    do_miss(32'h0000_5678, 1, 5, 16'hFFFF, 16, -1);
    do_miss(32'h0000_9ABC, 3, 1, 16'h0065, 7, -1);
    do_miss(32'h0000_1234, 2, 0, 16'hFFFF, 16, 2);
    do_miss(32'h0000_1234, 2, 0, 16'hFFFF, 16, -1);
    do_miss(32'hABCD_0120, 2, 1, 16'h0000, 0, -1);
    do_hit(32'h0000_0050, 4'b1010);
    do_miss(32'h0000_00F0, 6, 2, 16'h0000, 0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_hit($urandom, 4'(onehot(int'($urandom_range(0, 3)))));
      else
        do_miss($urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                16'h0000, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
